// File: rtl/multiplier_byte_pkg.sv
// Shared constants for the byte shift-and-add multiplier: FSM encodings and iteration count.
package multiplier_byte_pkg;

  localparam int unsigned MUL_WIDTH  = 8;
  localparam int unsigned MUL_PWIDTH = 2 * MUL_WIDTH;
  localparam int unsigned MUL_STEPS  = 8;
  localparam int unsigned MUL_CWIDTH = 4;

  typedef enum logic [1:0] {
    MUL_IDLE = 2'd0,
    MUL_RUN  = 2'd1,
    MUL_DONE = 2'd2
  } mul_state_e;

endpackage

// File: rtl/adder_byte.sv
// Combinational 8-bit ripple adder with carry in/out; the accumulation adder of the multiplier.
module adder_byte (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       carry_in,
  output logic [7:0] sum,
  output logic       carry_out
);

  always_comb begin
    {carry_out, sum} = 9'({1'b0, a}) + 9'({1'b0, b}) + 9'(carry_in);
  end

endmodule

// File: rtl/multiplier_byte.sv
// Sequential 8x8 unsigned shift-and-add multiplier; one partial-product add per clock
// through a single adder_byte, start/busy/done handshake, constant 9-cycle latency.
module multiplier_byte
  import multiplier_byte_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [MUL_WIDTH-1:0]  a,
  input  logic [MUL_WIDTH-1:0]  b,
  output logic                  busy,
  output logic                  done,
  output logic [MUL_PWIDTH-1:0] product
);

  mul_state_e            state;
  logic [MUL_WIDTH-1:0]  mcand;
  logic [MUL_WIDTH-1:0]  acc;
  logic [MUL_WIDTH-1:0]  mplr;
  logic [MUL_CWIDTH-1:0] count;

  logic [MUL_WIDTH-1:0]  add_b_c;
  logic [MUL_WIDTH-1:0]  add_sum_c;
  logic                  add_cout_c;
  logic [MUL_WIDTH-1:0]  acc_next_c;
  logic [MUL_WIDTH-1:0]  mplr_next_c;

  // Partial product is the multiplicand gated by the current multiplier LSB.
  assign add_b_c = mplr[0] ? mcand : '0;

  adder_byte u_adder (
    .a         (acc),
    .b         (add_b_c),
    .carry_in  (1'b0),
    .sum       (add_sum_c),
    .carry_out (add_cout_c)
  );

  // Right-shift {carry, sum, mplr} by one: the carry is kept as the new acc MSB.
  assign acc_next_c  = {add_cout_c, add_sum_c[MUL_WIDTH-1:1]};
  assign mplr_next_c = {add_sum_c[0], mplr[MUL_WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= MUL_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= '0;
      mcand   <= '0;
      acc     <= '0;
      mplr    <= '0;
      count   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        MUL_IDLE: begin
          if (start) begin
            mcand <= a;
            mplr  <= b;
            acc   <= '0;
            count <= '0;
            busy  <= 1'b1;
            state <= MUL_RUN;
          end
        end
        MUL_RUN: begin
          acc   <= acc_next_c;
          mplr  <= mplr_next_c;
          count <= count + MUL_CWIDTH'(1);
          if (count == MUL_CWIDTH'(MUL_STEPS - 1)) begin
            product <= {acc_next_c, mplr_next_c};
            busy    <= 1'b0;
            done    <= 1'b1;
            state   <= MUL_DONE;
          end
        end
        MUL_DONE: begin
          state <= MUL_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= MUL_IDLE;
        end
      endcase
    end
  end

endmodule
